// File: rtl/bus_pkg.sv
// Shared defaults, FSM encoding and command layout for the register-bus master.
package bus_pkg;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;
  localparam int SRC_W        = $clog2(DEF_NUM_REGS + 1);

  // Source index one past the last register selects the immediate field.
  localparam logic [SRC_W-1:0] SRC_IMM = SRC_W'(DEF_NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_XFER  = 2'd2
  } xfer_state_e;

  typedef struct packed {
    logic [SRC_W-1:0]        src;
    logic [DEF_NUM_REGS-1:0] dst;
    logic [DEF_DATA_W-1:0]   imm;
  } cmd_t;
endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with async reset; DEPTH must be a power of two so
// the pointers wrap naturally.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/bus_transfer_ctrl.sv
// Register-bus master: queues move commands and sequences the enable/latch
// strobes, one transfer per two cycles (DRIVE settles the bus, XFER captures).
module bus_transfer_ctrl
  import bus_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [$clog2(NUM_REGS+1)-1:0] cmd_src,
  input  logic [NUM_REGS-1:0]           cmd_dst,
  input  logic [DATA_W-1:0]             cmd_imm,
  output logic [NUM_REGS-1:0]           reg_enable,
  output logic [NUM_REGS-1:0]           reg_latch,
  inout  wire  [DATA_W-1:0]             bus,
  output logic [DATA_W-1:0]             bus_sample,
  output logic                          done,
  output logic                          busy,
  output logic                          err,
  input  logic                          err_clr
);
  localparam int SW = $clog2(NUM_REGS + 1);
  localparam logic [SW-1:0] IMM_SRC = SW'(NUM_REGS);

  typedef struct packed {
    logic [SW-1:0]       src;
    logic [NUM_REGS-1:0] dst;
    logic [DATA_W-1:0]   imm;
  } xfer_cmd_t;

  xfer_cmd_t           in_cmd, head_cmd, cur_q, cur_d;
  xfer_state_e         state_q, state_d;
  logic [NUM_REGS-1:0] en_q, en_d, lat_q, lat_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                drv_q, drv_d, done_q, done_d, err_q, err_d;
  logic                fifo_full, fifo_empty, push, pop, accept, cmd_bad;

  // Immediate source (index NUM_REGS) shifts out to zero: no register drives.
  function automatic logic [NUM_REGS-1:0] src_onehot(input logic [SW-1:0] s);
    return NUM_REGS'(1) << s;
  endfunction

  assign in_cmd    = {cmd_src, cmd_dst, cmd_imm};
  assign cmd_bad   = (cmd_src > IMM_SRC) || (cmd_dst == '0) ||
                     ((cmd_dst & src_onehot(cmd_src)) != '0);
  assign cmd_ready = !fifo_full;
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && !cmd_bad;

  cmd_fifo #(
    .WIDTH ($bits(xfer_cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_cmd),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    en_d     = '0;
    lat_d    = '0;
    drv_d    = 1'b0;
    done_d   = 1'b0;
    sample_d = sample_q;
    pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_DRIVE: begin
        state_d = ST_XFER;
        en_d    = en_q;
        drv_d   = drv_q;
        lat_d   = cur_q.dst;
      end
      ST_XFER: begin
        state_d  = ST_IDLE;
        done_d   = 1'b1;
        sample_d = bus;
      end
      default: state_d = ST_IDLE;
    endcase
    // Start the next transfer from IDLE or straight out of XFER (no gap).
    if ((state_q == ST_IDLE || state_q == ST_XFER) && !fifo_empty) begin
      pop     = 1'b1;
      cur_d   = head_cmd;
      state_d = ST_DRIVE;
      en_d    = src_onehot(head_cmd.src);
      drv_d   = (head_cmd.src == IMM_SRC);
    end
  end

  always_comb begin
    err_d = err_q;
    if (accept && cmd_bad) err_d = 1'b1;
    else if (err_clr)      err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      en_q     <= '0;
      lat_q    <= '0;
      drv_q    <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      en_q     <= en_d;
      lat_q    <= lat_d;
      drv_q    <= drv_d;
      done_q   <= done_d;
      sample_q <= sample_d;
      err_q    <= err_d;
    end
  end

  assign reg_enable = en_q;
  assign reg_latch  = lat_q;
  assign bus        = drv_q ? cur_q.imm : 'z;
  assign bus_sample = sample_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Bench for bus_transfer_ctrl: models the register file on the bus, runs a
// vector table, timing sequences and a random run against a queue model.
module tb_bus_transfer_ctrl;
  import bus_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0, cmd_ready, err_clr = 1'b0;
  logic [SRC_W-1:0] cmd_src = '0;
  logic [7:0]       cmd_dst = '0, cmd_imm = '0;
  logic [7:0]       reg_enable, reg_latch, bus_sample;
  logic             done, busy, err;
  wire  [7:0]       bus;

  logic [7:0] regs [8];
  logic [7:0] mreg [8];
  logic       pre_we = 1'b0;
  logic [2:0] pre_idx = '0;
  logic [7:0] pre_val = '0;
  logic       env_drv;
  logic [7:0] env_val;

  int   checks = 0, failures = 0;
  cmd_t q[$];

  always #5 clk = ~clk;

  bus_transfer_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .reg_enable(reg_enable), .reg_latch(reg_latch), .bus(bus),
    .bus_sample(bus_sample), .done(done), .busy(busy), .err(err),
    .err_clr(err_clr)
  );

  // Register file environment: drives the bus when enabled, captures on latch.
  always_comb begin
    env_drv = |reg_enable;
    env_val = '0;
    for (int i = 0; i < 8; i++) if (reg_enable[i]) env_val = regs[i];
  end
  assign bus = env_drv ? env_val : 'z;

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) if (reg_latch[i]) regs[i] <= bus;
    if (pre_we) regs[pre_idx] <= pre_val;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [7:0] v);
    pre_idx = 3'(idx); pre_val = v; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic send(input logic [SRC_W-1:0] s, input logic [7:0] d, input logic [7:0] im);
    cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_imm = im;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_done: no done within %0d cycles", maxc);
    end
  endtask

  // Spec rules: source out of range, empty mask, or a register latching itself.
  function automatic logic is_bad(input logic [SRC_W-1:0] s, input logic [7:0] d);
    if (s > SRC_IMM) return 1'b1;
    if (d == 8'h00) return 1'b1;
    if (s < SRC_IMM && d[s[2:0]]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic proc_done();
    cmd_t e;
    logic [7:0] ev;
    logic bad;
    if (!done) return;
    if (q.size() == 0) begin
      checks++; failures++;
      $display("FAIL rand done: unexpected done, sample %0h expected no transfer", bus_sample);
      return;
    end
    e  = q.pop_front();
    ev = (e.src == SRC_IMM) ? e.imm : mreg[e.src[2:0]];
    chk("rand sample", bus_sample, ev);
    for (int i = 0; i < 8; i++) if (e.dst[i]) mreg[i] = ev;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) if (regs[i] !== mreg[i]) bad = 1'b1;
    chk("rand regs", bad, 0);
  endtask

  typedef struct {
    logic [SRC_W-1:0] src;
    logic [7:0]       dst;
    logic [7:0]       imm;
    logic             bad;
    logic [7:0]       smp;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    logic ok, acc, bad;
    int   nd, k, cyc, first_low, last_done;
    logic [7:0] got[$];

    tbl[0]  = '{SRC_IMM, 8'h04, 8'hA5, 1'b0, 8'hA5};
    tbl[1]  = '{4'd2,    8'h90, 8'h00, 1'b0, 8'hA5};
    tbl[2]  = '{4'd2,    8'h04, 8'h00, 1'b1, 8'h00};
    tbl[3]  = '{4'd3,    8'h00, 8'h00, 1'b1, 8'h00};
    tbl[4]  = '{4'd9,    8'h01, 8'h00, 1'b1, 8'h00};
    tbl[5]  = '{4'd15,   8'h01, 8'h00, 1'b1, 8'h00};
    tbl[6]  = '{4'd5,    8'h01, 8'h00, 1'b0, 8'h15};
    tbl[7]  = '{SRC_IMM, 8'hFF, 8'h3C, 1'b0, 8'h3C};
    tbl[8]  = '{SRC_IMM, 8'h01, 8'h5A, 1'b0, 8'h5A};
    tbl[9]  = '{4'd0,    8'h80, 8'h00, 1'b0, 8'h5A};
    tbl[10] = '{SRC_IMM, 8'h00, 8'h77, 1'b1, 8'h00};
    tbl[11] = '{4'd7,    8'h7F, 8'h00, 1'b0, 8'h5A};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset ready", cmd_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset enable", reg_enable, 0);
    chk("reset latch", reg_latch, 0);
    chk("reset sample", bus_sample, 0);
    reset = 1'b0;
    @(negedge clk);

    // Immediate transfer: E1 drive, E2 latch, E3 done
    send(SRC_IMM, 8'h04, 8'hA5);
    @(negedge clk);
    chk("t1 E1 bus", bus, 8'hA5);
    chk("t1 E1 latch", reg_latch, 0);
    chk("t1 E1 enable", reg_enable, 0);
    @(negedge clk);
    chk("t1 E2 bus", bus, 8'hA5);
    chk("t1 E2 latch", reg_latch, 8'h04);
    @(negedge clk);
    chk("t1 E3 done", done, 1);
    chk("t1 E3 sample", bus_sample, 8'hA5);
    chk("t1 E3 reg2", regs[2], 8'hA5);
    @(negedge clk);
    chk("t1 E4 done", done, 0);
    chk("t1 E4 busy", busy, 0);

    // Register source broadcast
    preload(2, 8'hC3);
    send(4'd2, 8'h90, 8'h00);
    @(negedge clk);
    chk("t2 E1 enable", reg_enable, 8'h04);
    chk("t2 E1 latch", reg_latch, 0);
    @(negedge clk);
    chk("t2 E2 enable", reg_enable, 8'h04);
    chk("t2 E2 latch", reg_latch, 8'h90);
    chk("t2 E2 bus", bus, 8'hC3);
    @(negedge clk);
    chk("t2 E3 done", done, 1);
    chk("t2 E3 reg4", regs[4], 8'hC3);
    chk("t2 E3 reg7", regs[7], 8'hC3);
    chk("t2 E3 enable", reg_enable, 0);
    @(negedge clk);
    chk("t2 E4 done once", done, 0);

    // Vector table
    for (int i = 0; i < 8; i++) preload(i, 8'(8'h10 + i));
    for (int v = 0; v < 12; v++) begin
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk($sformatf("vec%0d err cleared", v), err, 0);
      send(tbl[v].src, tbl[v].dst, tbl[v].imm);
      chk($sformatf("vec%0d err", v), err, tbl[v].bad);
      if (!tbl[v].bad) begin
        wait_done(8, ok);
        chk($sformatf("vec%0d sample", v), bus_sample, tbl[v].smp);
        for (int i = 0; i < 8; i++)
          if (tbl[v].dst[i]) chk($sformatf("vec%0d reg%0d", v, i), regs[i], tbl[v].smp);
      end else begin
        nd = 0;
        repeat (4) begin
          @(negedge clk);
          if (done || reg_enable != 0 || reg_latch != 0) nd++;
        end
        chk($sformatf("vec%0d no activity", v), nd, 0);
        chk($sformatf("vec%0d busy", v), busy, 0);
      end
    end

    // err set wins over a coincident clear
    err_clr = 1'b1;
    send(4'd1, 8'h00, 8'h00);
    err_clr = 1'b0;
    chk("err set wins", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err clr", err, 0);

    // Back-to-back burst: fills the queue, wraps pointers, no idle gaps
    k = 0; cyc = 0; first_low = -1; last_done = -1; nd = 0;
    while (cyc < 60 && nd < 10) begin
      if (k < 10) begin
        cmd_valid = 1'b1; cmd_src = SRC_IMM;
        cmd_dst = 8'(1 << (k % 8)); cmd_imm = 8'(8'h40 + k);
      end else cmd_valid = 1'b0;
      acc = cmd_valid && cmd_ready;
      if (k < 10 && !cmd_ready && first_low < 0) first_low = k;
      @(negedge clk);
      cyc++;
      if (acc) k++;
      if (done) begin
        got.push_back(bus_sample);
        if (last_done >= 0) chk("burst done spacing", cyc - last_done, 2);
        last_done = cyc;
        nd++;
      end
    end
    cmd_valid = 1'b0;
    chk("burst count", nd, 10);
    chk("burst ready low after", first_low, 7);
    for (int i = 0; i < got.size(); i++) chk($sformatf("burst order %0d", i), got[i], 8'(8'h40 + i));
    chk("burst busy after last", busy, 0);

    // Reset in the middle of XFER with a second command queued
    preload(3, 8'h11);
    send(SRC_IMM, 8'h08, 8'hEE);
    chk("rst first accepted", busy, 1);
    send(SRC_IMM, 8'h08, 8'h77);
    @(negedge clk);
    chk("rst in xfer latch", reg_latch, 8'h08);
    #1 reset = 1'b1;
    #1;
    chk("rst latch drop", reg_latch, 0);
    chk("rst enable drop", reg_enable, 0);
    chk("rst bus released", 32'(bus === 8'hEE), 0);
    chk("rst done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst no done", nd, 0);
    chk("rst reg3 kept", regs[3], 8'h11);
    chk("rst busy", busy, 0);
    chk("rst sample", bus_sample, 0);
    chk("rst ready", cmd_ready, 1);

    // Random run against the queue model
    for (int i = 0; i < 8; i++) mreg[i] = regs[i];
    q.delete();
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      cmd_valid = ($urandom_range(0, 99) < 70);
      cmd_src   = ($urandom_range(0, 9) == 0) ? SRC_W'($urandom_range(9, 15))
                                               : SRC_W'($urandom_range(0, 8));
      cmd_dst   = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      cmd_imm   = 8'($urandom);
      err_clr   = ($urandom_range(0, 9) == 0);
      acc = cmd_valid && cmd_ready;
      bad = is_bad(cmd_src, cmd_dst);
      if (acc && bad) ok = 1'b1;
      else if (err_clr) ok = 1'b0;
      if (acc && !bad) q.push_back('{src: cmd_src, dst: cmd_dst, imm: cmd_imm});
      @(negedge clk);
      chk("rand err", err, ok);
      chk("rand enable onehot0", 32'($onehot0(reg_enable)), 1);
      proc_done();
    end
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
    for (int c = 0; c < 100 && (busy || q.size() != 0); c++) begin
      @(negedge clk);
      proc_done();
    end
    chk("drain busy", busy, 0);
    chk("drain queue", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
